// File: rtl/color_freq_classifier.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// color_freq_classifier
//
// Front end for a TCS3200-class colour sensor. The block steps the sensor
// filter through red, blue, green and clear. For each filter it waits a
// settling window, then counts rising edges of the sensor square wave over a
// fixed gate window. After all four channels are measured, it reports the
// dominant colour among red, green and blue.
//
// Ports
//   clk            system clock; the only clock used by the block
//   rst_n          synchronous, active-low reset
//   enable         block enable; when low, the FSM returns to IDLE
//   start          single-cycle sweep request (used only when CONTINUOUS = 0)
//   sensor_freq    asynchronous sensor output
//   scale          sensor S0/S1, fixed at SCALE_SEL
//   filter         sensor S2/S3: 00 red, 01 blue, 11 green, 10 clear
//   color          one-hot result: 001 red, 010 blue, 100 green, 000 none
//   *_count        channel counts from the last completed sweep
//   result_valid   one-cycle pulse when color and the counts update
//   busy           high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module color_freq_classifier #(
  parameter int unsigned GATE_CYCLES   = 100000,
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned CNT_W         = 16,
  parameter logic [1:0]  SCALE_SEL     = 2'b01,
  parameter int unsigned MIN_COUNT     = 8,
  parameter int unsigned MARGIN_SHIFT  = 3,
  parameter bit          CONTINUOUS    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             start,
  input  logic             sensor_freq,
  output logic [1:0]       scale,
  output logic [1:0]       filter,
  output logic [2:0]       color,
  output logic [CNT_W-1:0] red_count,
  output logic [CNT_W-1:0] green_count,
  output logic [CNT_W-1:0] blue_count,
  output logic [CNT_W-1:0] clear_count,
  output logic             result_valid,
  output logic             busy
);

  // The window counter is shared by SETTLE and GATE, so it is sized for the
  // longer of the two windows.
  localparam int unsigned CYC_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] GATE_LAST   = CYC_W'(GATE_CYCLES - 1);

  // Classification is done with one extra bit, so that S + (S >> MARGIN_SHIFT)
  // cannot wrap around.
  localparam int unsigned EW = CNT_W + 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETTLE   = 3'd1;
  localparam logic [2:0] ST_GATE     = 3'd2;
  localparam logic [2:0] ST_NEXT     = 3'd3;
  localparam logic [2:0] ST_CLASSIFY = 3'd4;

  localparam logic [1:0] F_RED   = 2'b00;
  localparam logic [1:0] F_BLUE  = 2'b01;
  localparam logic [1:0] F_GREEN = 2'b11;
  localparam logic [1:0] F_CLEAR = 2'b10;

  logic [2:0]       state_q, state_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic [1:0]       filter_q, filter_d;
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] tmp_q, tmp_d;
  logic [CNT_W-1:0] red_sh_q, red_sh_d, blue_sh_q, blue_sh_d;
  logic [CNT_W-1:0] green_sh_q, green_sh_d, clear_sh_q, clear_sh_d;
  logic [CNT_W-1:0] red_q, red_d, blue_q, blue_d;
  logic [CNT_W-1:0] green_q, green_d, clear_q, clear_d;
  logic [2:0]       color_q, color_d;
  logic             valid_q, valid_d;

  logic             rise;
  logic [EW-1:0]    r_x, g_x, b_x;
  logic [2:0]       color_new;

  // sync_q[0] and sync_q[1] form the metastability synchroniser. sync_q[2]
  // delays the signal by one more cycle, which is used for edge detection.
  assign rise = sync_q[1] & ~sync_q[2];

  // The candidate w wins only if it is strictly larger than both rivals
  // (so a tie for the maximum gives no winner), reaches the floor, and
  // clears the runner-up by the margin.
  function automatic logic is_winner(input logic [EW-1:0] w,
                                     input logic [EW-1:0] a,
                                     input logic [EW-1:0] b);
    logic [EW-1:0] s;
    s = (a > b) ? a : b;
    return (w > a) && (w > b) && (w >= EW'(MIN_COUNT)) &&
           (w >= s + (s >> MARGIN_SHIFT));
  endfunction

  assign r_x = {1'b0, red_sh_q};
  assign g_x = {1'b0, green_sh_q};
  assign b_x = {1'b0, blue_sh_q};
  assign color_new = {is_winner(g_x, r_x, b_x),
                      is_winner(b_x, r_x, g_x),
                      is_winner(r_x, g_x, b_x)};

  always_comb begin
    // NOTE: every *_d is first given a default from its register. Without
    // this, any path through the case statement that skips an assignment
    // would create a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    filter_d   = filter_q;
    sync_d     = {sync_q[1:0], sensor_freq};
    tmp_d      = tmp_q;
    red_sh_d   = red_sh_q;
    blue_sh_d  = blue_sh_q;
    green_sh_d = green_sh_q;
    clear_sh_d = clear_sh_q;
    red_d      = red_q;
    blue_d     = blue_q;
    green_d    = green_q;
    clear_d    = clear_q;
    color_d    = color_q;
    valid_d    = 1'b0;

    if (!enable) begin
      // Abort: the partial sweep is dropped. The published results are left
      // untouched, and the shadows are rewritten before their next use.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (CONTINUOUS || start) begin
            state_d  = ST_SETTLE;
            cnt_d    = '0;
            filter_d = F_RED;
          end
        end

        ST_SETTLE: begin
          tmp_d = '0;
          if (cnt_q == SETTLE_LAST) begin
            state_d = ST_GATE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CYC_W'(1);
          end
        end

        ST_GATE: begin
          if (rise && (tmp_q != '1)) begin
            tmp_d = tmp_q + CNT_W'(1);
          end
          if (cnt_q == GATE_LAST) begin
            state_d = ST_NEXT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CYC_W'(1);
          end
        end

        ST_NEXT: begin
          cnt_d   = '0;
          state_d = ST_SETTLE;
          case (filter_q)
            F_RED: begin
              red_sh_d = tmp_q;
              filter_d = F_BLUE;
            end
            F_BLUE: begin
              blue_sh_d = tmp_q;
              filter_d  = F_GREEN;
            end
            F_GREEN: begin
              green_sh_d = tmp_q;
              filter_d   = F_CLEAR;
            end
            F_CLEAR: begin
              clear_sh_d = tmp_q;
              state_d    = ST_CLASSIFY;
            end
          endcase
        end

        ST_CLASSIFY: begin
          red_d   = red_sh_q;
          blue_d  = blue_sh_q;
          green_d = green_sh_q;
          clear_d = clear_sh_q;
          color_d = color_new;
          valid_d = 1'b1;
          if (CONTINUOUS) begin
            state_d  = ST_SETTLE;
            cnt_d    = '0;
            filter_d = F_RED;
          end else begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: this block uses only non-blocking assignments. All registers then
  // update from the values they had before the edge, whatever order the
  // statements are written in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      filter_q   <= F_RED;
      sync_q     <= '0;
      tmp_q      <= '0;
      // NOTE: the four shadow registers are few and cheap, so they are reset
      // along with everything else. No pre-reset value can then ever be seen.
      red_sh_q   <= '0;
      blue_sh_q  <= '0;
      green_sh_q <= '0;
      clear_sh_q <= '0;
      red_q      <= '0;
      blue_q     <= '0;
      green_q    <= '0;
      clear_q    <= '0;
      color_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      filter_q   <= filter_d;
      sync_q     <= sync_d;
      tmp_q      <= tmp_d;
      red_sh_q   <= red_sh_d;
      blue_sh_q  <= blue_sh_d;
      green_sh_q <= green_sh_d;
      clear_sh_q <= clear_sh_d;
      red_q      <= red_d;
      blue_q     <= blue_d;
      green_q    <= green_d;
      clear_q    <= clear_d;
      color_q    <= color_d;
      valid_q    <= valid_d;
    end
  end

  assign scale        = SCALE_SEL;
  assign filter       = filter_q;
  assign color        = color_q;
  assign red_count    = red_q;
  assign green_count  = green_q;
  assign blue_count   = blue_q;
  assign clear_count  = clear_q;
  assign result_valid = valid_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_color_freq_classifier.sv
`timescale 1ns/1ps
module tb_color_freq_classifier;

  localparam int SWEEP = 421;   // 4*(4+100+1)+1 cycles from first SETTLE to result_valid

  logic       clk;
  logic       rst_n, enable, start, sen_m;
  logic [1:0] scale_m, filter_m;
  logic [2:0] color_m;
  logic [7:0] red_m, green_m, blue_m, clear_m;
  logic       valid_m, busy_m;

  logic       enable_s, start_s, sen_s;
  logic [1:0] scale_s, filter_s;
  logic [2:0] color_s;
  logic [3:0] red_s, green_s, blue_s, clear_s;
  logic       valid_s, busy_s;

  logic       enable_c, start_c, sen_c;
  logic [1:0] scale_c, filter_c;
  logic [2:0] color_c;
  logic [7:0] red_c, green_c, blue_c, clear_c;
  logic       valid_c, busy_c;

  // Sensor period in clk cycles, indexed by filter code (00 red, 01 blue,
  // 10 clear, 11 green). 0 holds the sensor low.
  int per_m[4];
  int per_s[4];
  int per_c[4];

  int total = 0;
  int bad   = 0;

  color_freq_classifier #(
    .GATE_CYCLES(100), .SETTLE_CYCLES(4), .CNT_W(8), .SCALE_SEL(2'b01),
    .MIN_COUNT(5), .MARGIN_SHIFT(2), .CONTINUOUS(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .sensor_freq(sen_m),
    .scale(scale_m), .filter(filter_m), .color(color_m),
    .red_count(red_m), .green_count(green_m), .blue_count(blue_m), .clear_count(clear_m),
    .result_valid(valid_m), .busy(busy_m)
  );

  color_freq_classifier #(
    .GATE_CYCLES(100), .SETTLE_CYCLES(4), .CNT_W(4), .SCALE_SEL(2'b01),
    .MIN_COUNT(5), .MARGIN_SHIFT(2), .CONTINUOUS(1'b0)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable_s), .start(start_s), .sensor_freq(sen_s),
    .scale(scale_s), .filter(filter_s), .color(color_s),
    .red_count(red_s), .green_count(green_s), .blue_count(blue_s), .clear_count(clear_s),
    .result_valid(valid_s), .busy(busy_s)
  );

  color_freq_classifier #(
    .GATE_CYCLES(100), .SETTLE_CYCLES(4), .CNT_W(8), .SCALE_SEL(2'b01),
    .MIN_COUNT(5), .MARGIN_SHIFT(2), .CONTINUOUS(1'b1)
  ) dut_cont (
    .clk(clk), .rst_n(rst_n), .enable(enable_c), .start(start_c), .sensor_freq(sen_c),
    .scale(scale_c), .filter(filter_c), .color(color_c),
    .red_count(red_c), .green_count(green_c), .blue_count(blue_c), .clear_count(clear_c),
    .result_valid(valid_c), .busy(busy_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sensor models: the waveform restarts (high first) whenever the filter changes.
  initial begin : model_m
    logic [1:0] last_f;
    int ph;
    sen_m = 1'b0; last_f = 2'b00; ph = 0;
    forever begin
      @(negedge clk);
      if (filter_m !== last_f) begin ph = 0; last_f = filter_m; end
      else if (per_m[filter_m] > 0) ph = (ph + 1) % per_m[filter_m];
      sen_m = (per_m[filter_m] > 0) && (ph < per_m[filter_m] / 2);
    end
  end

  initial begin : model_s
    logic [1:0] last_f;
    int ph;
    sen_s = 1'b0; last_f = 2'b00; ph = 0;
    forever begin
      @(negedge clk);
      if (filter_s !== last_f) begin ph = 0; last_f = filter_s; end
      else if (per_s[filter_s] > 0) ph = (ph + 1) % per_s[filter_s];
      sen_s = (per_s[filter_s] > 0) && (ph < per_s[filter_s] / 2);
    end
  end

  initial begin : model_c
    logic [1:0] last_f;
    int ph;
    sen_c = 1'b0; last_f = 2'b00; ph = 0;
    forever begin
      @(negedge clk);
      if (filter_c !== last_f) begin ph = 0; last_f = filter_c; end
      else if (per_c[filter_c] > 0) ph = (ph + 1) % per_c[filter_c];
      sen_c = (per_c[filter_c] > 0) && (ph < per_c[filter_c] / 2);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Pulses start on DUT 0 (main) or 1 (saturating), then watches 480 cycles.
  // lat is the cycle index of the first result_valid, counted from the
  // first SETTLE cycle (cycle 0).
  task automatic run_sweep(input int which, output int lat, output int pulses);
    lat = -1; pulses = 0;
    if (which == 0) start = 1'b1; else start_s = 1'b1;
    @(negedge clk);
    start = 1'b0; start_s = 1'b0;
    for (int k = 0; k < 480; k++) begin
      if ((which == 0) ? valid_m : valid_s) begin
        pulses++;
        if (lat < 0) lat = k;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (valid_m) pulses++;
    end
    total++; if (color_m !== 3'b000) begin bad++; $display("FAIL reset_color got=%b exp=000", color_m); end
    total++; if ({red_m, green_m, blue_m, clear_m} !== 32'd0) begin bad++; $display("FAIL reset_counts got=%h exp=0", {red_m, green_m, blue_m, clear_m}); end
    total++; if (filter_m !== 2'b00) begin bad++; $display("FAIL reset_filter got=%b exp=00", filter_m); end
    total++; if (scale_m !== 2'b01) begin bad++; $display("FAIL reset_scale got=%b exp=01", scale_m); end
    total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_m); end
    total++; if (pulses != 0) begin bad++; $display("FAIL reset_valid pulses=%0d exp=0", pulses); end
    total++; if ({busy_s, busy_c, color_s, red_s, green_s, blue_s, clear_s} !== 21'd0) begin bad++; $display("FAIL reset_aux got=%h exp=0", {busy_s, busy_c, color_s, red_s, green_s, blue_s, clear_s}); end
    total++; if ({scale_s, scale_c, filter_s, filter_c} !== 8'b01_01_00_00) begin bad++; $display("FAIL reset_aux_pins got=%b exp=01010000", {scale_s, scale_c, filter_s, filter_c}); end
    rst_n = 1'b1; enable = 1'b1; enable_s = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_red_dominant;
    int lat, pulses;
    per_m = '{10, 40, 8, 40};
    run_sweep(0, lat, pulses);
    total++; if (lat != SWEEP) begin bad++; $display("FAIL red_latency got=%0d exp=%0d", lat, SWEEP); end
    total++; if (pulses != 1) begin bad++; $display("FAIL red_pulses got=%0d exp=1", pulses); end
    total++; if (color_m !== 3'b001) begin bad++; $display("FAIL red_color got=%b exp=001", color_m); end
    total++; if (red_m !== 8'd10) begin bad++; $display("FAIL red_red got=%0d exp=10", red_m); end
    total++; if (blue_m < 8'd2 || blue_m > 8'd3) begin bad++; $display("FAIL red_blue got=%0d exp=2..3", blue_m); end
    total++; if (green_m < 8'd2 || green_m > 8'd3) begin bad++; $display("FAIL red_green got=%0d exp=2..3", green_m); end
    total++; if (clear_m < 8'd12 || clear_m > 8'd13) begin bad++; $display("FAIL red_clear got=%0d exp=12..13", clear_m); end
  endtask

  task automatic test_abort;
    int pulses = 0;
    int lat, np;
    per_m = '{10, 40, 8, 40};
    start = 1'b1; @(negedge clk); start = 1'b0;   // now in cycle 0
    repeat (150) @(negedge clk);                  // cycle 150: blue GATE
    total++; if (busy_m !== 1'b1 || filter_m !== 2'b01) begin bad++; $display("FAIL abort_in_blue busy=%b filter=%b exp busy=1 filter=01", busy_m, filter_m); end
    enable = 1'b0;
    @(negedge clk);
    total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy_m); end
    for (int k = 0; k < 480; k++) begin
      if (valid_m) pulses++;
      @(negedge clk);
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL abort_valid pulses=%0d exp=0", pulses); end
    total++; if (color_m !== 3'b001 || red_m !== 8'd10) begin bad++; $display("FAIL abort_hold color=%b red=%0d exp 001/10", color_m, red_m); end
    total++; if (blue_m < 8'd2 || blue_m > 8'd3 || green_m < 8'd2 || green_m > 8'd3 || clear_m < 8'd12 || clear_m > 8'd13)
      begin bad++; $display("FAIL abort_hold_bgc got=%0d/%0d/%0d exp 2..3/2..3/12..13", blue_m, green_m, clear_m); end
    enable = 1'b1;
    @(negedge clk);
    run_sweep(0, lat, np);
    total++; if (lat != SWEEP || np != 1) begin bad++; $display("FAIL abort_resweep lat=%0d pulses=%0d exp %0d/1", lat, np, SWEEP); end
    total++; if (color_m !== 3'b001 || red_m !== 8'd10) begin bad++; $display("FAIL abort_resweep_result color=%b red=%0d exp 001/10", color_m, red_m); end
  endtask

  task automatic test_margin;
    int lat, pulses;
    per_m = '{10, 0, 0, 11};
    run_sweep(0, lat, pulses);
    total++; if (pulses != 1) begin bad++; $display("FAIL margin_pulses got=%0d exp=1", pulses); end
    total++; if (red_m !== 8'd10) begin bad++; $display("FAIL margin_red got=%0d exp=10", red_m); end
    total++; if (green_m !== 8'd9) begin bad++; $display("FAIL margin_green got=%0d exp=9", green_m); end
    total++; if (blue_m !== 8'd0 || clear_m !== 8'd0) begin bad++; $display("FAIL margin_idle got=%0d/%0d exp=0/0", blue_m, clear_m); end
    total++; if (color_m !== 3'b000) begin bad++; $display("FAIL margin_color got=%b exp=000", color_m); end
  endtask

  task automatic test_saturation;
    int lat, pulses;
    run_sweep(1, lat, pulses);
    total++; if (lat != SWEEP || pulses != 1) begin bad++; $display("FAIL sat_timing lat=%0d pulses=%0d exp %0d/1", lat, pulses, SWEEP); end
    total++; if ({red_s, green_s, blue_s, clear_s} !== 16'hFFFF) begin bad++; $display("FAIL sat_counts got=%h exp=ffff", {red_s, green_s, blue_s, clear_s}); end
    total++; if (color_s !== 3'b000) begin bad++; $display("FAIL sat_color got=%b exp=000", color_s); end
  endtask

  task automatic test_continuous;
    int nv = 0;
    int p;
    logic [1:0] fexp;
    enable_c = 1'b1;
    @(negedge clk);                                // cycle 0 of the first sweep
    for (int k = 0; k <= 1300; k++) begin
      p = k % SWEEP;
      if (valid_c) begin
        nv++;
        total++; if (k != SWEEP * nv) begin bad++; $display("FAIL cont_period pulse=%0d at=%0d exp=%0d", nv, k, SWEEP * nv); end
        total++; if (color_c !== 3'b100 || green_c !== 8'd25) begin bad++; $display("FAIL cont_result color=%b green=%0d exp 100/25", color_c, green_c); end
        total++; if ({red_c, blue_c, clear_c} !== 24'd0) begin bad++; $display("FAIL cont_others got=%h exp=0", {red_c, blue_c, clear_c}); end
      end
      if (k < 3 * SWEEP && (p == 50 || p == 150 || p == 260 || p == 370)) begin
        case (p)
          50:      fexp = 2'b00;
          150:     fexp = 2'b01;
          260:     fexp = 2'b11;
          default: fexp = 2'b10;
        endcase
        total++; if (filter_c !== fexp) begin bad++; $display("FAIL cont_filter cycle=%0d got=%b exp=%b", k, filter_c, fexp); end
      end
      @(negedge clk);
    end
    total++; if (nv != 3) begin bad++; $display("FAIL cont_pulse_count got=%0d exp=3", nv); end
    enable_c = 1'b0;
    @(negedge clk);
    total++; if (busy_c !== 1'b0) begin bad++; $display("FAIL cont_stop_busy got=%b exp=0", busy_c); end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; start = 1'b0;
    enable_s = 1'b0; start_s = 1'b0;
    enable_c = 1'b0; start_c = 1'b0;
    per_m = '{10, 10, 10, 10};
    per_s = '{4, 4, 4, 4};
    per_c = '{0, 0, 0, 4};
    test_reset();
    test_red_dominant();
    test_abort();
    test_margin();
    test_saturation();
    test_continuous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
